// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, frame-checker states and config helpers shared by the UART RX frame checker.
package uart_pkg;
  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP1  = 3'd3,
    S_STOP2  = 3'd4
  } state_e;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return (len < 4'd5) ? 4'd5 : (len > max_len) ? max_len : len;
  endfunction

  function automatic par_mode_e norm_mode(input logic [2:0] mode);
    return (mode > 3'd4) ? PAR_NONE : par_mode_e'(mode);
  endfunction
endpackage

// File: rtl/uart_rx_frame_chk_if.sv
// uart_rx_frame_chk_if: bit-sample input stream and completed-frame outputs of the RX frame checker.
interface uart_rx_frame_chk_if #(parameter int MAX_DATA_WIDTH = 9);
  logic                      start_det;
  logic                      bit_strb;
  logic                      sampled_bit;
  logic [MAX_DATA_WIDTH-1:0] p_data;
  logic                      data_vld;
  logic                      parity_err;
  logic                      stop_err;
  logic                      busy;

  modport master (
    output start_det, bit_strb, sampled_bit,
    input  p_data, data_vld, parity_err, stop_err, busy
  );

  modport slave (
    input  start_det, bit_strb, sampled_bit,
    output p_data, data_vld, parity_err, stop_err, busy
  );
endinterface

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: saturating event counter, clear has priority over increment.
module uart_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/uart_rx_frame_chk.sv
// uart_rx_frame_chk: assembles LSB-first data bits, checks parity and stop bits, counts errors.
module uart_rx_frame_chk
  import uart_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [3:0]           cfg_data_len,
  input  logic [2:0]           cfg_par_mode,
  input  logic                 cfg_stop2,
  input  logic                 cnt_clr,
  uart_rx_frame_chk_if.slave   rx,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stop_err_cnt
);
  localparam int         BW      = $clog2(MAX_DATA_WIDTH + 1);
  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_WIDTH);

  state_e                    state_q, state_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [MAX_DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [3:0]                len_q, len_d;
  par_mode_e                 mode_q, mode_d;
  logic                      stop2_q, stop2_d;
  logic                      par_q, par_d;
  logic                      rx_par_q, rx_par_d;
  logic                      stop_bad_q, stop_bad_d;
  logic                      data_vld_q, data_vld_d;
  logic                      parity_err_q, parity_err_d;
  logic                      stop_err_q, stop_err_d;
  logic                      done;
  logic                      exp_par;

  assign exp_par = (mode_q == PAR_EVEN) ? par_q :
                   (mode_q == PAR_ODD)  ? ~par_q :
                   (mode_q == PAR_MARK);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    len_d        = len_q;
    mode_d       = mode_q;
    stop2_d      = stop2_q;
    par_d        = par_q;
    rx_par_d     = rx_par_q;
    stop_bad_d   = stop_bad_q;
    data_vld_d   = 1'b0;
    parity_err_d = 1'b0;
    stop_err_d   = 1'b0;
    done         = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (rx.start_det) begin
      state_d    = S_DATA;
      bit_cnt_d  = '0;
      shreg_d    = '0;
      par_d      = 1'b0;
      rx_par_d   = 1'b0;
      stop_bad_d = 1'b0;
      len_d      = clamp_len(cfg_data_len, MAX_LEN);
      mode_d     = norm_mode(cfg_par_mode);
      stop2_d    = cfg_stop2;
    end else if (rx.bit_strb) begin
      case (state_q)
        S_DATA: begin
          shreg_d[bit_cnt_q] = rx.sampled_bit;
          par_d              = par_q ^ rx.sampled_bit;
          bit_cnt_d          = bit_cnt_q + BW'(1);
          if (bit_cnt_d == BW'(len_q)) state_d = (mode_q == PAR_NONE) ? S_STOP1 : S_PARITY;
        end
        S_PARITY: begin
          rx_par_d = rx.sampled_bit;
          state_d  = S_STOP1;
        end
        S_STOP1: begin
          stop_bad_d = stop_bad_q | ~rx.sampled_bit;
          state_d    = stop2_q ? S_STOP2 : S_IDLE;
          done       = ~stop2_q;
        end
        S_STOP2: begin
          stop_bad_d = stop_bad_q | ~rx.sampled_bit;
          state_d    = S_IDLE;
          done       = 1'b1;
        end
        default: ;
      endcase
      if (done) begin
        data_vld_d   = 1'b1;
        p_data_d     = shreg_q;
        stop_err_d   = stop_bad_d;
        parity_err_d = (mode_q != PAR_NONE) && (exp_par != rx_par_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      len_q        <= 4'd5;
      mode_q       <= PAR_NONE;
      stop2_q      <= 1'b0;
      par_q        <= 1'b0;
      rx_par_q     <= 1'b0;
      stop_bad_q   <= 1'b0;
      data_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      stop2_q      <= stop2_d;
      par_q        <= par_d;
      rx_par_q     <= rx_par_d;
      stop_bad_q   <= stop_bad_d;
      data_vld_q   <= data_vld_d;
      parity_err_q <= parity_err_d;
      stop_err_q   <= stop_err_d;
    end
  end

  assign rx.p_data     = p_data_q;
  assign rx.data_vld   = data_vld_q;
  assign rx.parity_err = parity_err_q;
  assign rx.stop_err   = stop_err_q;
  assign rx.busy       = (state_q != S_IDLE);

  // Counters see the registered completion pulse, so they advance the cycle after data_vld.
  uart_sat_cnt #(.W(CNT_WIDTH)) u_par_cnt (
    .clk (clk),
    .rst (rst),
    .inc (data_vld_q & parity_err_q),
    .clr (cnt_clr),
    .cnt (par_err_cnt)
  );

  uart_sat_cnt #(.W(CNT_WIDTH)) u_stop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (data_vld_q & stop_err_q),
    .clr (cnt_clr),
    .cnt (stop_err_cnt)
  );
endmodule
